insr_decode_stage: RTL

//  Registered MIPS instruction-decode stage with valid/ready handshake on both sides.

---
 rtl/insr_decode_pkg.sv | 27 ++
 rtl/insr_decode_stage_field_decode.sv | 69 ++++++
 rtl/insr_decode_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/insr_decode_pkg.sv
// rtl/insr_decode_pkg.sv - MIPS decode stage encodings (format, opcode, funct constants)
package insr_decode_pkg;

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/insr_decode_stage_field_decode.sv
// rtl/insr_decode_stage_field_decode.sv - combinational instruction -> decoded bundle (DECODE_ILLEGAL_EN enables illegal check)
module insr_field_decode
    import insr_decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic [31:0]       i_instr,
    input  logic [PC_W-1:0]   i_pc,
    output logic [5:0]        o_op_code,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic [4:0]        o_rd,
    output logic [4:0]        o_shamt,
    output logic [5:0]        o_funct,
    output logic [1:0]        o_fmt,
    output logic [DATA_W-1:0] o_imm_ext,
    output logic [PC_W-1:0]   o_jaddr,
    output logic              o_illegal
);

    logic [15:0]     w_imm;
    logic [PC_W-1:0] w_pc4;
    logic [PC_W-1:0] w_region_mask;

    assign o_op_code = i_instr[31:26];
    assign o_rs      = i_instr[25:21];
    assign o_rt      = i_instr[20:16];
    assign o_rd      = i_instr[15:11];
    assign o_shamt   = i_instr[10:6];
    assign o_funct   = i_instr[5:0];
    assign w_imm     = i_instr[15:0];

    always_comb begin
        o_fmt = FMT_I;
        if (o_op_code == OP_RTYPE)
            o_fmt = FMT_R;
        else if (o_op_code == OP_J || o_op_code == OP_JAL)
            o_fmt = FMT_J;
    end

    always_comb begin
        o_imm_ext = DATA_W'($signed(w_imm));
        if (o_op_code == OP_ANDI || o_op_code == OP_ORI || o_op_code == OP_XORI)
            o_imm_ext = DATA_W'(w_imm);
        else if (o_op_code == OP_LUI)
            o_imm_ext = DATA_W'({w_imm, 16'h0000});
    end

    // Keep the 256 MB region bits of pc+4 and splice in the word target; the mask form works for any PC_W >= 28.
    assign w_pc4         = i_pc + PC_W'(4);
    assign w_region_mask = ~PC_W'(28'hFFF_FFFF);
    assign o_jaddr       = (w_pc4 & w_region_mask) | PC_W'({i_instr[25:0], 2'b00});

`ifdef DECODE_ILLEGAL_EN
    logic w_op_ok;
    logic w_fn_ok;

    assign w_op_ok = (o_op_code == OP_RTYPE) || (o_op_code >= OP_J && o_op_code <= OP_LUI)
                   || (o_op_code == OP_LW) || (o_op_code == OP_SW);
    assign w_fn_ok = (o_funct == FN_SLL) || (o_funct == FN_SRL) || (o_funct == FN_SRA)
                   || (o_funct == FN_JR) || (o_funct >= FN_ADD && o_funct <= FN_NOR)
                   || (o_funct == FN_SLT) || (o_funct == FN_SLTU);
    assign o_illegal = !w_op_ok || (o_op_code == OP_RTYPE && !w_fn_ok);
`else
    assign o_illegal = 1'b0;
`endif

endmodule

// File: rtl/insr_decode_stage.sv
// rtl/insr_decode_stage.sv - registered MIPS decode stage with 2-entry skid FIFO (DECODE_ILLEGAL_EN selects illegal check)
module insr_decode_stage
    import insr_decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [5:0]        op_code,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [1:0]        fmt,
    output logic [DATA_W-1:0] imm_ext,
    output logic [PC_W-1:0]   out_jaddr,
    output logic              illegal
);

    localparam int ENTRY_W = PC_W + 32 + 2 + DATA_W + PC_W + 1;

    logic [5:0]        w_op_code;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [4:0]        w_shamt;
    logic [5:0]        w_funct;
    logic [1:0]        w_fmt;
    logic [DATA_W-1:0] w_imm_ext;
    logic [PC_W-1:0]   w_jaddr;
    logic              w_illegal;
    logic [ENTRY_W-1:0] w_entry;
    logic              w_push;
    logic              w_pop;

    logic [ENTRY_W-1:0] r_slot0;
    logic [ENTRY_W-1:0] r_slot1;
    logic [1:0]         r_count;

    insr_field_decode #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_field_decode (
        .i_instr   (in_instr),
        .i_pc      (in_pc),
        .o_op_code (w_op_code),
        .o_rs      (w_rs),
        .o_rt      (w_rt),
        .o_rd      (w_rd),
        .o_shamt   (w_shamt),
        .o_funct   (w_funct),
        .o_fmt     (w_fmt),
        .o_imm_ext (w_imm_ext),
        .o_jaddr   (w_jaddr),
        .o_illegal (w_illegal)
    );

    assign w_entry = {in_pc, w_op_code, w_rs, w_rt, w_rd, w_shamt, w_funct,
                      w_fmt, w_imm_ext, w_jaddr, w_illegal};

    // in_ready depends only on the registered count, never on out_ready.
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0)
                        r_slot0 <= w_entry;
                    else
                        r_slot1 <= w_entry;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_slot0 <= r_slot1;
                    r_count <= r_count - 2'd1;
                end
                // Simultaneous push/pop only happens at count 1 (count 2 blocks the push).
                2'b11: r_slot0 <= w_entry;
                default: ;
            endcase
        end
    end

    assign {out_pc, op_code, rs, rt, rd, shamt, funct, fmt, imm_ext, out_jaddr, illegal} = r_slot0;

endmodule
